// File: rtl/bytebeat_pkg.sv
// Shared types and constants for the bytebeat audio path: PCM sample type,
// the mid-scale (silence) level, the mixer FSM states and the default
// sample-rate divider for a 10 MHz clock at 8 kHz.
package bytebeat_pkg;

  typedef logic [7:0] pcm_t;

  localparam pcm_t PCM_MID        = 8'h80;
  localparam int   SAMPLE_CLK_DIV = 1250;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } mix_state_e;

endpackage

// File: rtl/bytebeat_sample_mixer_if.sv
// Generator-to-mixer sample bus.
// Handshake: a channel's sample transfers in a cycle where both pcm_vld[i]
// and pcm_rdy[i] are high. The mixer raises pcm_rdy[i] for one cycle per
// audio tick whether or not pcm_vld[i] is high, and never derives pcm_rdy
// combinationally from pcm_vld, so a generator may drive vld from rdy.
// dbg_state exposes the mixer FSM state for observation.
interface bytebeat_sample_mixer_if
  import bytebeat_pkg::*;
#(
  parameter int NUM_CH = 8
) ();

  logic [8*NUM_CH-1:0] pcm_in;
  logic [NUM_CH-1:0]   pcm_vld;
  logic [NUM_CH-1:0]   pcm_rdy;
  mix_state_e          dbg_state;

  modport master (output pcm_in, output pcm_vld, input pcm_rdy, input dbg_state);
  modport slave  (input pcm_in, input pcm_vld, output pcm_rdy, output dbg_state);

endinterface

// File: rtl/sample_rate_divider.sv
// Free-running clock divider: counts 0..CLK_DIV-1 and pulses tick for one
// cycle while the count sits at CLK_DIV-1. Reusable for any paced stage.
module sample_rate_divider #(
  parameter int CLK_DIV = 1250
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal-count detect and wrap-around increment.
  always_comb begin
    tick  = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bytebeat_sample_mixer.sv
// Rate-controlled mixer: on every divider tick it pops one sample from each
// channel in order (one channel per cycle), averages the enabled channels
// (muted ones count as mid-scale) and presents the result with a strobe.
// A channel that is enabled but not valid reuses its last sample.
// Optional build macro MEGABYTEBEAT_MIXER_UNDERRUN_EN adds a saturating
// per-tick underrun counter; without it underrun_cnt reads 0.
// NUM_CH must match the NUM_CH of the connected interface instance.
module bytebeat_sample_mixer
  import bytebeat_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CLK_DIV = SAMPLE_CLK_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bytebeat_sample_mixer_if.slave  pcm_if,
  input  logic [NUM_CH-1:0]       ch_en,
  output pcm_t                    sample_out,
  output logic                    sample_strobe,
  output logic [7:0]              underrun_cnt
);

  localparam int SHIFT = $clog2(NUM_CH);
  localparam int AW    = 8 + SHIFT;

  logic tick;

  sample_rate_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  mix_state_e        state_q, state_d;
  logic [SHIFT-1:0]  idx_q, idx_d;
  logic [AW-1:0]     acc_q, acc_d, acc_sum;
  pcm_t              last_q [NUM_CH];
  pcm_t              last_d [NUM_CH];
  pcm_t              sample_out_q, sample_out_d;
  pcm_t              cur_in, contrib;
  logic              xfer, last_ch;
  logic [NUM_CH-1:0] rdy;

  // Datapath for the channel currently addressed by idx.
  always_comb begin
    cur_in  = pcm_if.pcm_in[8*int'(idx_q) +: 8];
    xfer    = pcm_if.pcm_vld[idx_q];
    contrib = !ch_en[idx_q] ? PCM_MID : (xfer ? cur_in : last_q[idx_q]);
    acc_sum = acc_q + AW'(contrib);
    last_ch = (idx_q == SHIFT'(NUM_CH - 1));
  end

  // Next-state, accumulate and pop-strobe logic for the mixer FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    last_d       = last_q;
    sample_out_d = sample_out_q;
    rdy          = '0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = COLLECT;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      COLLECT: begin
        rdy[idx_q] = 1'b1;
        acc_d      = acc_sum;
        if (xfer) last_d[idx_q] = cur_in;
        if (last_ch) begin
          state_d      = OUTPUT;
          sample_out_d = acc_sum[AW-1:SHIFT];
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUTPUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator, hold registers and output sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      last_q       <= '{default: PCM_MID};
      sample_out_q <= PCM_MID;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      last_q       <= last_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign pcm_if.pcm_rdy   = rdy;
  assign pcm_if.dbg_state = state_q;
  assign sample_out       = sample_out_q;
  assign sample_strobe    = (state_q == OUTPUT);

`ifdef MEGABYTEBEAT_MIXER_UNDERRUN_EN
  logic       miss;
  logic       miss_seen_q, miss_seen_d;
  logic [7:0] under_q, under_d;

  // Collapse this tick's misses into one count, saturating at 0xFF.
  always_comb begin
    miss        = (state_q == COLLECT) && ch_en[idx_q] && !xfer;
    miss_seen_d = miss_seen_q;
    under_d     = under_q;
    if (state_q == IDLE) begin
      miss_seen_d = 1'b0;
    end else if (state_q == COLLECT) begin
      miss_seen_d = miss_seen_q | miss;
      if (last_ch && (miss_seen_q | miss) && (under_q != 8'hFF)) under_d = under_q + 1'b1;
    end
  end

  // Underrun tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_seen_q <= 1'b0;
      under_q     <= 8'h00;
    end else begin
      miss_seen_q <= miss_seen_d;
      under_q     <= under_d;
    end
  end

  assign underrun_cnt = under_q;
`else
  assign underrun_cnt = 8'h00;
`endif

  // The divider period leaves room for a full collect pass, so a tick must
  // only ever arrive while idle.
  a_tick_in_idle: assert property (@(posedge clk) disable iff (!rst_n) tick |-> state_q == IDLE);

endmodule

// File: tb/tb_bytebeat_sample_mixer.sv
// Bench for bytebeat_sample_mixer with NUM_CH=8, CLK_DIV=16.
module tb_bytebeat_sample_mixer;
  import bytebeat_pkg::*;

  localparam int NUM_CH    = 8;
  localparam int CLK_DIV   = 16;
  localparam int MAX_WAIT  = 3 * CLK_DIV;
  // Edges after the last reset edge: CLK_DIV-1 to reach the tick count,
  // then NUM_CH+1 from tick to strobe.
  localparam int FIRST_LAT = (CLK_DIV - 1) + (NUM_CH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  pcm_t              sample_out;
  logic              sample_strobe;
  logic [7:0]        underrun_cnt;

  bytebeat_sample_mixer_if #(.NUM_CH(NUM_CH)) pcm_if ();

  bytebeat_sample_mixer #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcm_if        (pcm_if),
    .ch_en         (ch_en),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int         compares = 0;
  int         fails    = 0;
  logic [7:0] exp_q[$];
  pcm_t       last_m [NUM_CH];
  int         cnt_m;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) last_m[i] = PCM_MID;
    cnt_m = 0;
    exp_q.delete();
  endtask

  // Drive one tick's worth of inputs and push the expected mix.
  task automatic drive_mix(input logic [8*NUM_CH-1:0] vals, input logic [NUM_CH-1:0] vld,
                           input logic [NUM_CH-1:0] en);
    int sum;
    pcm_if.pcm_in  = vals;
    pcm_if.pcm_vld = vld;
    ch_en          = en;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (vld[i]) last_m[i] = vals[8*i +: 8];
      if (en[i]) sum += int'(last_m[i]);
      else       sum += int'(PCM_MID);
    end
`ifdef MEGABYTEBEAT_MIXER_UNDERRUN_EN
    if (((en & ~vld) != '0) && cnt_m < 255) cnt_m++;
`endif
    exp_q.push_back(8'(sum / NUM_CH));
  endtask

  // Wait (bounded) for the next strobe; n = cycles waited.
  task automatic wait_strobe(output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
      if (sample_strobe) seen = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit seen; int n; logic [7:0] exp_v;
    rst_n = 1'b0; ch_en = '0; pcm_if.pcm_in = '0; pcm_if.pcm_vld = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compares++; if (sample_out !== 8'h80) begin fails++; $display("FAIL reset_sample_out: got %h want 80", sample_out); end
    compares++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b want 0", sample_strobe); end
    compares++; if (pcm_if.pcm_rdy !== '0) begin fails++; $display("FAIL reset_rdy: got %h want 00", pcm_if.pcm_rdy); end
    compares++; if (underrun_cnt !== 8'h00) begin fails++; $display("FAIL reset_underrun: got %h want 00", underrun_cnt); end
    compares++; if (pcm_if.dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", pcm_if.dbg_state); end
    drive_mix({NUM_CH{8'h40}}, '1, '1);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_strobe(seen, n);
    exp_v = exp_q.pop_front();
    compares++; if (!seen || n != FIRST_LAT) begin fails++; $display("FAIL first_latency: got %0d cycles (seen=%0b) want %0d", n, seen, FIRST_LAT); end
    compares++; if (sample_out !== exp_v) begin fails++; $display("FAIL first_sample: got %h want %h", sample_out, exp_v); end
  endtask

  task automatic test_all_valid();
    bit seen; int n; int nxt; bit order_ok; bit strobe_low;
    logic [NUM_CH-1:0] exp_rdy; logic [7:0] exp_v;
    for (int p = 0; p < 2; p++) begin
      drive_mix({NUM_CH{8'h40}}, '1, '1);
      seen = 0; n = 0; nxt = 0; order_ok = 1; strobe_low = 1;
      while (!seen && n < MAX_WAIT) begin
        @(posedge clk); #1;
        n++;
        if (sample_strobe) begin
          if (n == 1) strobe_low = 0;
          else        seen = 1;
        end
        if (pcm_if.pcm_rdy != '0) begin
          if (nxt >= NUM_CH) order_ok = 0;
          else begin
            exp_rdy = '0; exp_rdy[nxt] = 1'b1;
            if (pcm_if.pcm_rdy !== exp_rdy) order_ok = 0;
            nxt++;
          end
        end
      end
      exp_v = exp_q.pop_front();
      compares++; if (!seen || n != CLK_DIV) begin fails++; $display("FAIL strobe_period: got %0d cycles want %0d", n, CLK_DIV); end
      compares++; if (!strobe_low) begin fails++; $display("FAIL strobe_width: got 2+ cycles want 1"); end
      compares++; if (!order_ok || nxt != NUM_CH) begin fails++; $display("FAIL rdy_order: got %0d ordered pops (ok=%0b) want %0d", nxt, order_ok, NUM_CH); end
      compares++; if (sample_out !== exp_v) begin fails++; $display("FAIL all_valid_sample: got %h want %h", sample_out, exp_v); end
    end
  endtask

  task automatic test_mixed();
    bit seen; int n; logic [7:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      drive_mix(64'h00000000000000FF, '1, (k == 0) ? 8'hFF : 8'hFE);
      wait_strobe(seen, n);
      exp_v = exp_q.pop_front();
      compares++; if (!seen || sample_out !== exp_v) begin fails++; $display("FAIL mixed_%0d: got %h (seen=%0b) want %h", k, sample_out, seen, exp_v); end
    end
  endtask

  task automatic test_underrun();
    bit seen; int n; logic [7:0] exp_v;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive_mix(64'h00000000A0000000, '1, '1);
      else        drive_mix(64'h0000000055000000, 8'hF7, '1);
      wait_strobe(seen, n);
      exp_v = exp_q.pop_front();
      compares++; if (!seen || sample_out !== exp_v) begin fails++; $display("FAIL underrun_hold_%0d: got %h (seen=%0b) want %h", k, sample_out, seen, exp_v); end
    end
    compares++; if (underrun_cnt !== 8'(cnt_m)) begin fails++; $display("FAIL underrun_count: got %0d want %0d", underrun_cnt, cnt_m); end
  endtask

  task automatic test_muted_no_vld();
    bit seen; int n; logic [7:0] exp_v;
    drive_mix('0, 8'hDF, 8'hDF);
    wait_strobe(seen, n);
    exp_v = exp_q.pop_front();
    compares++; if (!seen || sample_out !== exp_v) begin fails++; $display("FAIL muted_sample: got %h (seen=%0b) want %h", sample_out, seen, exp_v); end
    compares++; if (underrun_cnt !== 8'(cnt_m)) begin fails++; $display("FAIL muted_no_underrun: got %0d want %0d", underrun_cnt, cnt_m); end
  endtask

  task automatic test_underrun_saturate();
    bit seen; int n; logic [7:0] exp_v;
    for (int k = 0; k < 300; k++) begin
      drive_mix('0, 8'hF7, '1);
      wait_strobe(seen, n);
      exp_v = exp_q.pop_front();
      compares++; if (!seen || sample_out !== exp_v) begin fails++; $display("FAIL sat_sample_%0d: got %h (seen=%0b) want %h", k, sample_out, seen, exp_v); end
    end
    compares++; if (underrun_cnt !== 8'(cnt_m)) begin fails++; $display("FAIL underrun_saturate: got %0d want %0d", underrun_cnt, cnt_m); end
  endtask

  task automatic test_reset_mid_collect();
    bit seen; int n; bit found; int strobes; logic [7:0] exp_v;
    drive_mix({NUM_CH{8'h40}}, '1, '1);
    found = 0; n = 0;
    while (!found && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
      if (pcm_if.pcm_rdy[4]) found = 1;
    end
    compares++; if (!found) begin fails++; $display("FAIL midreset_reach_idx4: got no rdy[4] want rdy[4] within %0d", MAX_WAIT); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    compares++; if (sample_out !== 8'h80) begin fails++; $display("FAIL midreset_sample_out: got %h want 80", sample_out); end
    compares++; if (pcm_if.pcm_rdy !== '0) begin fails++; $display("FAIL midreset_rdy: got %h want 00", pcm_if.pcm_rdy); end
    compares++; if (pcm_if.dbg_state !== IDLE) begin fails++; $display("FAIL midreset_state: got %0d want IDLE", pcm_if.dbg_state); end
    compares++; if (underrun_cnt !== 8'h00) begin fails++; $display("FAIL midreset_underrun: got %h want 00", underrun_cnt); end
    strobes = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      @(posedge clk); #1;
      if (sample_strobe) strobes++;
    end
    compares++; if (strobes != 0) begin fails++; $display("FAIL midreset_no_strobe: got %0d strobes want 0", strobes); end
    model_reset();
    drive_mix(64'h7060504030201000, 8'hF7, '1);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_strobe(seen, n);
    exp_v = exp_q.pop_front();
    compares++; if (!seen || n != FIRST_LAT) begin fails++; $display("FAIL midreset_latency: got %0d cycles (seen=%0b) want %0d", n, seen, FIRST_LAT); end
    compares++; if (sample_out !== exp_v) begin fails++; $display("FAIL midreset_fresh_mix: got %h want %h", sample_out, exp_v); end
    compares++; if (underrun_cnt !== 8'(cnt_m)) begin fails++; $display("FAIL midreset_fresh_underrun: got %0d want %0d", underrun_cnt, cnt_m); end
  endtask

  task automatic test_random();
    bit seen; int n; logic [7:0] exp_v;
    for (int k = 0; k < 8; k++) begin
      drive_mix({$urandom, $urandom}, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_strobe(seen, n);
      exp_v = exp_q.pop_front();
      compares++; if (!seen || sample_out !== exp_v) begin fails++; $display("FAIL random_sample_%0d: got %h (seen=%0b) want %h", k, sample_out, seen, exp_v); end
      compares++; if (underrun_cnt !== 8'(cnt_m)) begin fails++; $display("FAIL random_underrun_%0d: got %0d want %0d", k, underrun_cnt, cnt_m); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_all_valid();
    test_mixed();
    test_underrun();
    test_muted_no_vld();
    test_underrun_saturate();
    test_reset_mid_collect();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
